// File: rtl/sound_i2s_tx_if.sv
// -----------------------------------------------------------------------------
// sound_i2s_tx_if
// Sample hand-off between the sound generator (master) and the I2S
// transmitter (slave).
//   enable     : master -> slave, 1 = play latched samples, 0 = mute
//   sample_l   : master -> slave, left/mono sample, two's complement
//   sample_r   : master -> slave, right sample (SOUND_I2S_TX_STEREO_EN only)
//   sample_req : slave -> master, one-clk pulse on the cycle samples are latched
// Optional macro: SOUND_I2S_TX_STEREO_EN adds sample_r.
// -----------------------------------------------------------------------------
interface sound_i2s_tx_if #(
   parameter int SAMPLE_BITS = 24
);
   logic                   enable;
   logic [SAMPLE_BITS-1:0] sample_l;
`ifdef SOUND_I2S_TX_STEREO_EN
   logic [SAMPLE_BITS-1:0] sample_r;
`endif
   logic                   sample_req;

   modport master (
`ifdef SOUND_I2S_TX_STEREO_EN
      output sample_r,
`endif
      output enable,
      output sample_l,
      input  sample_req
   );

   modport slave (
`ifdef SOUND_I2S_TX_STEREO_EN
      input  sample_r,
`endif
      input  enable,
      input  sample_l,
      output sample_req
   );
endinterface

// File: rtl/sound_i2s_tx.sv
// -----------------------------------------------------------------------------
// sound_i2s_tx
// Serialises the mixed sample stream into a Philips I2S bitstream for a codec
// running in slave mode. bclk and lrck are derived from clk; one stereo frame
// is 2*SLOT_BITS bclk periods, and one sample pair is latched per frame.
//
// Ports:
//   clk     : system clock
//   resetn  : synchronous, active-low reset (clears everything, aborts frame)
//   smp     : sound_i2s_tx_if.slave (enable, sample_l, [sample_r], sample_req)
//   bclk    : I2S bit clock, period 2*CLK_DIV clk
//   lrck    : word select, 0 = left slot, 1 = right slot
//   dacdat  : serial data, changes after bclk falls, MSB first, one-bclk delay
//
// Optional macro: SOUND_I2S_TX_STEREO_EN
//   defined   : right slot carries sample_r
//   undefined : right slot repeats the latched left/mono sample
// -----------------------------------------------------------------------------
module sound_i2s_tx #(
   parameter int CLK_DIV     = 8,
   parameter int SAMPLE_BITS = 24,
   parameter int SLOT_BITS   = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   sound_i2s_tx_if.slave        smp,
   output logic                 bclk,
   output logic                 lrck,
   output logic                 dacdat
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int B_W   = $clog2(SLOT_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [B_W-1:0]   B_LAST   = B_W'(SLOT_BITS - 1);
   localparam logic [B_W-1:0]   B_WORD   = B_W'(SAMPLE_BITS);

   logic [DIV_W-1:0]       div_cnt;
   logic [B_W-1:0]         bit_idx;
   logic [SAMPLE_BITS-1:0] h_l;
`ifdef SOUND_I2S_TX_STEREO_EN
   logic [SAMPLE_BITS-1:0] h_r;
`endif
   logic [SAMPLE_BITS-1:0] shift_reg;

   logic                   div_last;
   logic                   fall_evt;
   logic [B_W-1:0]         bit_nxt;
   logic                   slot_start;
   logic                   left_start;
   logic                   in_word;
   logic [SAMPLE_BITS-1:0] new_l;
   logic [SAMPLE_BITS-1:0] right_word;
`ifdef SOUND_I2S_TX_STEREO_EN
   logic [SAMPLE_BITS-1:0] new_r;
`endif

   always_comb begin
      div_last   = (div_cnt == DIV_LAST);
      // bclk is about to fall when the divider wraps while bclk is high
      fall_evt   = div_last & bclk;
      bit_nxt    = (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;
      slot_start = fall_evt & (bit_nxt == '0);
      // lrck currently high means the slot about to start is the left one
      left_start = slot_start & lrck;
      // b = 1..SAMPLE_BITS carries the word; b = 0 is the I2S one-bit delay
      in_word    = (bit_nxt != '0) && (bit_nxt <= B_WORD);
      new_l      = smp.enable ? smp.sample_l : '0;
`ifdef SOUND_I2S_TX_STEREO_EN
      new_r      = smp.enable ? smp.sample_r : '0;
      right_word = h_r;
`else
      // h_l only changes at left-slot start, so it still holds this frame's word
      right_word = h_l;
`endif
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_cnt        <= '0;
         bclk           <= 1'b0;
         bit_idx        <= '0;
         lrck           <= 1'b0;
         dacdat         <= 1'b0;
         smp.sample_req <= 1'b0;
         h_l            <= '0;
`ifdef SOUND_I2S_TX_STEREO_EN
         h_r            <= '0;
`endif
         shift_reg      <= '0;
      end else begin
         smp.sample_req <= left_start;

         if (div_last) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         if (left_start) begin
            h_l <= new_l;
`ifdef SOUND_I2S_TX_STEREO_EN
            h_r <= new_r;
`endif
         end

         // All serial outputs move only on bclk falling so the DAC sees
         // stable data on the following rising edge.
         if (fall_evt) begin
            bit_idx <= bit_nxt;
            if (slot_start) begin
               lrck      <= ~lrck;
               dacdat    <= 1'b0;
               // The freshly latched word goes out in the slot that starts now
               shift_reg <= lrck ? new_l : right_word;
            end else if (in_word) begin
               dacdat    <= shift_reg[SAMPLE_BITS-1];
               shift_reg <= {shift_reg[SAMPLE_BITS-2:0], 1'b0};
            end else begin
               dacdat    <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sound_i2s_tx.sv
module tb_sound_i2s_tx;

   localparam int CLK_DIV = 8;
   localparam int SB      = 24;
   localparam int SLOT    = 32;
   localparam int FRAME   = 2 * CLK_DIV * 2 * SLOT;

   logic clk = 1'b0;
   logic resetn;
   logic bclk, lrck, dacdat;

   sound_i2s_tx_if #(.SAMPLE_BITS(SB)) smp_if ();

   sound_i2s_tx #(.CLK_DIV(CLK_DIV), .SAMPLE_BITS(SB), .SLOT_BITS(SLOT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .smp    (smp_if.slave),
      .bclk   (bclk),
      .lrck   (lrck),
      .dacdat (dacdat)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // n = clk edges since reset release; every output is a closed-form
   // function of n plus the words latched at each frame boundary.
   int          n = 0;
   logic [SB-1:0] ml = '0;
   logic [SB-1:0] mr = '0;
   logic        chk_en = 1'b0;

   always @(posedge clk) begin
      if (!resetn) begin
         n  = 0;
         ml = '0;
         mr = '0;
         chk_en = 1'b1;
      end else begin
         n++;
         if (n % FRAME == 0) begin
            ml = smp_if.enable ? smp_if.sample_l : '0;
`ifdef SOUND_I2S_TX_STEREO_EN
            mr = smp_if.enable ? smp_if.sample_r : '0;
`else
            mr = ml;
`endif
         end
      end
   end

   function automatic int m_fall();
      return (n / CLK_DIV) / 2;
   endfunction
   function automatic int m_b();
      return m_fall() % SLOT;
   endfunction
   function automatic logic m_lr();
      return logic'((m_fall() / SLOT) % 2);
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         logic [SB-1:0] w;
         logic          e_dat;
         int            b;
         b = m_b();
         w = m_lr() ? mr : ml;
         e_dat = (b >= 1 && b <= SB) ? w[SB-b] : 1'b0;
         chk("bclk", 32'(bclk), 32'((n / CLK_DIV) % 2));
         chk("lrck", 32'(lrck), 32'(m_lr()));
         chk("dacdat", 32'(dacdat), 32'(e_dat));
         chk("sample_req", 32'(smp_if.sample_req), 32'(n > 0 && n % FRAME == 0));
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_req(output int cnt);
      cnt = 0;
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(posedge clk); #1;
         cnt++;
         if (smp_if.sample_req) return;
      end
      chk("req_timeout", 32'(cnt), 32'(FRAME));
   endtask

   // Collect nb bits of dacdat, each sampled just after a bclk rising edge.
   task automatic rises(input int nb, output logic [31:0] w);
      logic prev;
      logic ok;
      w = '0;
      for (int i = 0; i < nb; i++) begin
         ok   = 1'b0;
         prev = bclk;
         for (int k = 0; k < 4 * CLK_DIV && !ok; k++) begin
            @(posedge clk); #1;
            if (!prev && bclk) ok = 1'b1;
            prev = bclk;
         end
         if (!ok) begin
            chk("bclk_timeout", 32'(i), 32'(nb));
            return;
         end
         w = {w[30:0], dacdat};
      end
   endtask

   int          cnt;
   logic [31:0] wl, wr;
   logic [31:0] exp_a5;

   initial begin
      exp_a5 = {1'b0, 24'hA5F00F, 7'd0};
      resetn = 1'b0;
      smp_if.enable   = 1'b1;
      smp_if.sample_l = 24'hA5F00F;
`ifdef SOUND_I2S_TX_STEREO_EN
      smp_if.sample_r = 24'hA5F00F;
`endif
      repeat (10) @(negedge clk);
      chk("reset_bclk", 32'(bclk), 32'd0);
      chk("reset_lrck", 32'(lrck), 32'd0);
      chk("reset_dacdat", 32'(dacdat), 32'd0);
      chk("reset_req", 32'(smp_if.sample_req), 32'd0);
      resetn = 1'b1;

      // Scenario 1: first request latency and width
      wait_req(cnt);
      chk("first_req_latency", 32'(cnt), 32'd1024);
      @(posedge clk); #1;
      chk("req_width", 32'(smp_if.sample_req), 32'd0);

      // Scenario 2: slot contents of the first latched frame
      rises(SLOT, wl);
      rises(SLOT, wr);
      chk("left_slot_a5", wl, exp_a5);
      chk("right_slot_a5", wr, exp_a5);

      // Scenario 3: sample_l change mid-slot only affects the next frame
      wait_req(cnt);
      rises(16, wl);
      smp_if.sample_l = 24'h000001;
      wait_req(cnt);
      rises(SLOT, wl);
      chk("left_slot_lsb", wl, {1'b0, 24'h000001, 7'd0});
`ifndef SOUND_I2S_TX_STEREO_EN
      rises(SLOT, wr);
      chk("right_slot_lsb", wr, {1'b0, 24'h000001, 7'd0});
`endif
      smp_if.sample_l = 24'hA5F00F;

      // Scenario 4: enable drop mid-frame
      wait_req(cnt);
      rises(10, wl);
      smp_if.enable = 1'b0;
      rises(22, wl);
      chk("tail_after_disable", wl, {10'd0, exp_a5[21:0]});
      wait_req(cnt);
      wait_req(cnt);
      chk("req_period_muted", 32'(cnt), 32'(FRAME));
      rises(SLOT, wl);
      rises(SLOT, wr);
      chk("left_slot_muted", wl, 32'd0);
      chk("right_slot_muted", wr, 32'd0);

      // Scenario 5: reset at b=12 of a right slot
      smp_if.enable = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         if (m_lr() && m_b() == 12) break;
      end
      chk("right_b12_reached", 32'(m_lr() && m_b() == 12), 32'd1);
      resetn = 1'b0;
      @(posedge clk); #1;
      chk("midreset_bclk", 32'(bclk), 32'd0);
      chk("midreset_lrck", 32'(lrck), 32'd0);
      chk("midreset_dacdat", 32'(dacdat), 32'd0);
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      wait_req(cnt);
      chk("req_latency_after_reset", 32'(cnt), 32'd1024);

      // Randomised traffic, checked every cycle against the model
      for (int k = 0; k < 6 * FRAME; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 149) == 0) smp_if.sample_l = 24'($urandom());
`ifdef SOUND_I2S_TX_STEREO_EN
         if ($urandom_range(0, 149) == 0) smp_if.sample_r = 24'($urandom());
`endif
         if ($urandom_range(0, 399) == 0) smp_if.enable = ~smp_if.enable;
      end

      // Scenario 6: full-scale extremes
      @(negedge clk);
      smp_if.enable   = 1'b1;
      smp_if.sample_l = 24'h7FFFFF;
`ifdef SOUND_I2S_TX_STEREO_EN
      smp_if.sample_r = 24'h800000;
`endif
      wait_req(cnt);
      rises(SLOT, wl);
      rises(SLOT, wr);
      chk("left_slot_pos_fs", wl, {1'b0, 24'h7FFFFF, 7'd0});
`ifdef SOUND_I2S_TX_STEREO_EN
      chk("right_slot_neg_fs", wr, {1'b0, 24'h800000, 7'd0});
`else
      chk("right_slot_pos_fs", wr, {1'b0, 24'h7FFFFF, 7'd0});
`endif

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
